difftest_commit_batcher: RTL and testbench
==========================================

# difftest_commit_batcher

Parametrised successor to the single-lane instruction-commit difftest hook. It collects up to NUM_LANES commit records per cycle from the ROB commit stage and compacts them, in lane order, into a circular buffer. Records drain one per cycle through a valid/ready port to the DPI-C reporting stage. While draining, the block checks ROB-index ordering and accumulates a retired-instruction count. It sits between the core's commit lanes and the per-record difftest DPI call, so simulation no longer needs one DPI call per lane per cycle.

## Interface
Parameters:
- NUM_LANES, 6, commit lanes sampled per cycle (1..8)
- DEPTH, 16, buffer entries; power of two, >= 2*NUM_LANES
- ROB_IDX_W, 10, width of robIdx field

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- enable  in  1  gates enqueue; when 0, lane valids are ignored
- in_valid  in  NUM_LANES  per-lane record valid; any pattern, holes allowed
- in_rec  in  NUM_LANES*REC_W  lane i record at bits [i*REC_W +: REC_W]
- in_ready  out  1  buffer can absorb a full lane group this cycle
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head
- out_rec  out  REC_W  head record
- occupancy  out  $clog2(DEPTH+1)  entries held
- instr_cnt  out  64  retired instructions drained since reset
- err_overflow  out  1  sticky; enqueue attempted while in_ready=0
- err_order  out  1  sticky; robIdx sequence violation on drain

## Operation
- Enqueue fires when enable && in_ready && |in_valid.
- Valid lanes are written at wptr, wptr+1, … in ascending lane index. wptr advances by popcount(in_valid). Pointers wrap mod DEPTH.
- in_ready = (DEPTH − occupancy) >= NUM_LANES, using registered occupancy. Same-cycle dequeue does not credit space.
- When enable && |in_valid && !in_ready, nothing is written and err_overflow is set.
- Dequeue fires on out_valid && out_ready. rptr advances by 1.
- occupancy_next = occupancy + n_enq − deq, where n_enq is 0 when enqueue does not fire.
- Each dequeue adds 1 + nFused to instr_cnt (64-bit wrap). Skip records are counted.
- Order check runs on each dequeue:
  - The first dequeue after reset only loads exp_rob = robIdx + 1 (mod 2^ROB_IDX_W).
  - Each later dequeue sets err_order if robIdx != exp_rob, then loads exp_rob = robIdx + 1.
  - Fused instructions occupy one ROB entry.
- err flags clear only on reset.
- Reset values: occupancy 0, out_valid 0, in_ready 1, instr_cnt 0, err_overflow 0, err_order 0, exp_rob invalid. Pointers are 0, and out_rec is 0.
- Reset asserted mid-operation discards all buffered records. No drain occurs in the reset cycle.

## Timing
- Enqueue-to-out_valid latency is 1 cycle. There is no flow-through bypass.
- out_rec is driven from storage at rptr (registered data, combinational read). It stays stable while out_valid && !out_ready.
- Throughput: NUM_LANES in, 1 out per cycle.
- Simultaneous enqueue and dequeue in the same cycle is legal.
- Full and empty are determined by occupancy only:
  - Full is occupancy == DEPTH. in_ready drops earlier, at free < NUM_LANES.
  - Empty is occupancy == 0, which gives out_valid = 0.
- err_* and instr_cnt update the cycle after the triggering event.

## Structure
- Package difftest_commit_pkg holds:
  - typedef commit_rec_t: skip, isRVC, rfwen, fpwen, wdest[7:0], pc[63:0], instr[31:0], robIdx[ROB_IDX_W-1:0], nFused[7:0], coreid[7:0]
  - localparam REC_W = $bits(commit_rec_t)
  - a popcount function
- One sub-module: difftest_lane_compactor (combinational). It maps the valid lane mask to per-slot write enables and lane selects, offset from wptr.
- Storage is a flop array of DEPTH × REC_W.

## Test plan
- Reset, then in_valid=6'b111111 with robIdx 0..5, out_ready=1 → records drain in order over 6 cycles, first at cycle+1. instr_cnt=6, err_order=0.
- in_valid=6'b100101 (lanes 0,2,5) → occupancy 3; drain order is lane0, lane2, lane5.
- out_ready=0 and enqueue full groups → in_ready falls when occupancy=12 (DEPTH=16). An extra valid group sets err_overflow and occupancy stays 12.
- Wrap: 40 records streamed with out_ready toggling 50% → all appear in order, pointers wrap, no spurious errors.
- robIdx 1023 then 0 → no error (mod wrap). Sequence 3 then 5 → err_order=1 and stays set.
- Record with nFused=1 → instr_cnt += 2. Assert reset with 5 entries held → next cycle occupancy 0, out_valid 0, counters 0.

Source files
------------

// File: rtl/difftest_commit_batcher_pkg.sv
// Shared types and helpers for the difftest commit batcher.
// Commit record layout matches what the DPI reporting stage unpacks.
package difftest_commit_pkg;

    localparam int unsigned ROB_IDX_W = 10;
    localparam int unsigned MAX_LANES = 8;

    typedef struct packed {
        logic                 skip;
        logic                 isRVC;
        logic                 rfwen;
        logic                 fpwen;
        logic [7:0]           wdest;
        logic [63:0]          pc;
        logic [31:0]          instr;
        logic [ROB_IDX_W-1:0] robIdx;
        logic [7:0]           nFused;
        logic [7:0]           coreid;
    } commit_rec_t;

    localparam int unsigned REC_W = $bits(commit_rec_t);

    // Number of set bits in a lane-valid mask (zero-extended to MAX_LANES).
    function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < int'(MAX_LANES); i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/difftest_commit_batcher_if.sv
// Commit-lane input, drain port and status bundle of the commit batcher.
// slave is the batcher; master is the commit stage plus DPI consumer.
interface difftest_commit_batcher_if #(
    parameter int unsigned NUM_LANES = 6,
    parameter int unsigned DEPTH     = 16
);
    import difftest_commit_pkg::*;

    logic                         enable;
    logic [NUM_LANES-1:0]         in_valid;
    logic [NUM_LANES*REC_W-1:0]   in_rec;
    logic                         in_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [REC_W-1:0]             out_rec;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;
    logic [63:0]                  instr_cnt;
    logic                         err_overflow;
    logic                         err_order;

    modport slave (
        input  enable, in_valid, in_rec, out_ready,
        output in_ready, out_valid, out_rec, occupancy, instr_cnt,
               err_overflow, err_order
    );

    modport master (
        output enable, in_valid, in_rec, out_ready,
        input  in_ready, out_valid, out_rec, occupancy, instr_cnt,
               err_overflow, err_order
    );

endinterface

// File: rtl/difftest_commit_batcher_lane_compactor.sv
// Maps a sparse lane-valid mask onto consecutive buffer slots starting at
// the write pointer, giving each slot its write enable and source lane.
module difftest_lane_compactor
    import difftest_commit_pkg::*;
#(
    parameter  int unsigned NUM_LANES = 6,
    parameter  int unsigned DEPTH     = 16,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] i_valid,
    input  logic [PTR_W-1:0]     i_wptr,
    output logic [DEPTH-1:0]     o_slot_we,
    output logic [LANE_W-1:0]    o_slot_lane [DEPTH]
);

    logic [PTR_W-1:0] w_off;
    logic [PTR_W-1:0] w_slot;

    // Valid lanes claim slots in ascending lane order; pointer math wraps.
    always_comb begin
        o_slot_we = '0;
        for (int s = 0; s < int'(DEPTH); s++) begin
            o_slot_lane[s] = '0;
        end
        w_off  = '0;
        w_slot = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (i_valid[i]) begin
                w_slot              = i_wptr + w_off;
                o_slot_we[w_slot]   = 1'b1;
                o_slot_lane[w_slot] = LANE_W'(i);
                w_off               = w_off + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/difftest_commit_batcher.sv
// Batches up to NUM_LANES commit records per cycle into a circular buffer and
// drains them one per cycle, tracking robIdx order and retired-instr count.
module difftest_commit_batcher
    import difftest_commit_pkg::*;
#(
    parameter int unsigned NUM_LANES = 6,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ROB_IDX_W = difftest_commit_pkg::ROB_IDX_W
) (
    input  logic                     clock,
    input  logic                     reset,
    difftest_commit_batcher_if.slave bus
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    commit_rec_t           r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [OCC_W-1:0]      r_occ;
    logic [63:0]           r_instr_cnt;
    logic                  r_err_ovf;
    logic                  r_err_ord;
    logic                  r_exp_vld;
    logic [ROB_IDX_W-1:0]  r_exp_rob;

    commit_rec_t           w_lane_rec [NUM_LANES];
    logic [DEPTH-1:0]      w_slot_we;
    logic [LANE_W-1:0]     w_slot_lane [DEPTH];
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_any;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_ovf;
    logic [3:0]            w_cnt;
    logic [OCC_W-1:0]      w_n_enq;
    commit_rec_t           w_head;

    always_comb begin
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            w_lane_rec[i] = commit_rec_t'(bus.in_rec[i*REC_W +: REC_W]);
        end
    end

    // Space is judged on registered occupancy only; a same-cycle drain never credits.
    assign w_in_ready  = (DEPTH - 32'(r_occ)) >= NUM_LANES;
    assign w_out_valid = (r_occ != '0);
    assign w_any       = |bus.in_valid;
    assign w_enq       = bus.enable && w_in_ready && w_any;
    assign w_ovf       = bus.enable && w_any && !w_in_ready;
    assign w_deq       = w_out_valid && bus.out_ready;
    assign w_cnt       = popcount(MAX_LANES'(bus.in_valid));
    assign w_n_enq     = w_enq ? OCC_W'(w_cnt) : '0;
    assign w_head      = r_mem[r_rptr];

    difftest_lane_compactor #(
        .NUM_LANES (NUM_LANES),
        .DEPTH     (DEPTH)
    ) u_compactor (
        .i_valid     (bus.in_valid),
        .i_wptr      (r_wptr),
        .o_slot_we   (w_slot_we),
        .o_slot_lane (w_slot_lane)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                r_mem[s] <= '0;
            end
        end else if (w_enq) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                if (w_slot_we[s]) begin
                    r_mem[s] <= w_lane_rec[w_slot_lane[s]];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            r_wptr <= r_wptr + PTR_W'(w_n_enq);
            r_rptr <= r_rptr + PTR_W'(w_deq);
            r_occ  <= r_occ + w_n_enq - OCC_W'(w_deq);
        end
    end

    // The first drain after reset only seeds the expected robIdx.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr_cnt <= '0;
            r_err_ovf   <= 1'b0;
            r_err_ord   <= 1'b0;
            r_exp_vld   <= 1'b0;
            r_exp_rob   <= '0;
        end else begin
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end
            if (w_deq) begin
                r_instr_cnt <= r_instr_cnt + 64'd1 + 64'(w_head.nFused);
                r_exp_vld   <= 1'b1;
                r_exp_rob   <= w_head.robIdx + ROB_IDX_W'(1);
                if (r_exp_vld && (w_head.robIdx != r_exp_rob)) begin
                    r_err_ord <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_rec      = w_head;
    assign bus.occupancy    = r_occ;
    assign bus.instr_cnt    = r_instr_cnt;
    assign bus.err_overflow = r_err_ovf;
    assign bus.err_order    = r_err_ord;

endmodule

// File: tb/tb_difftest_commit_batcher.sv
// Self-checking bench for difftest_commit_batcher: a per-cycle vector table
// followed by directed overflow, wrap-stream, robIdx-order and reset sequences.
module tb_difftest_commit_batcher;
    import difftest_commit_pkg::*;

    localparam int NL    = 6;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    difftest_commit_batcher_if #(.NUM_LANES(NL), .DEPTH(DEPTH)) bus ();

    difftest_commit_batcher #(
        .NUM_LANES (NL),
        .DEPTH     (DEPTH),
        .ROB_IDX_W (10)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        en;
        logic [5:0]  valid;
        logic [9:0]  base;
        logic        rdy;
        int          occ;
        logic        ovalid;
        logic [9:0]  rob;
        logic [7:0]  wdest;
        logic [63:0] cnt;
    } vec_t;

    vec_t        vt [17];
    int          n_checks = 0;
    int          n_errors = 0;
    commit_rec_t h;
    logic [9:0]  q [$];
    logic [5:0]  masks [6];
    int          m_occ, sent, drained, mi, n;
    logic [9:0]  nrob;
    logic [5:0]  m;
    logic        rdy, deq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Valid lanes get consecutive robIdx in lane order; holes carry junk.
    task automatic drive(input logic en, input logic [NL-1:0] mask,
                         input logic [9:0] base, input logic [7:0] nf);
        logic [9:0]  k;
        commit_rec_t r;
        k = '0;
        for (int i = 0; i < NL; i++) begin
            r        = '0;
            r.wdest  = 8'(i);
            r.coreid = 8'hC0;
            if (mask[i]) begin
                r.robIdx = base + k;
                r.pc     = 64'h8000_0000 + 64'(r.robIdx) * 64'd4;
                r.instr  = 32'h0000_0013;
                r.nFused = nf;
                k        = k + 10'd1;
            end else begin
                r.robIdx = 10'h155;
                r.nFused = 8'hFF;
            end
            bus.in_rec[i*REC_W +: REC_W] = r;
        end
        bus.enable   = en;
        bus.in_valid = mask;
    endtask

    task automatic chk_head(input string name, input logic [9:0] rob);
        commit_rec_t hr;
        hr = bus.out_rec;
        chk(name, 64'(hr.robIdx), 64'(rob));
    endtask

    initial begin
        // en, valid, base, rdy | occ, out_valid, head rob, head wdest, instr_cnt
        vt[0]  = '{1'b1, 6'h3F, 10'd0,  1'b1, 6, 1'b1, 10'd0,  8'd0, 64'd0};
        vt[1]  = '{1'b0, 6'h00, 10'd0,  1'b1, 5, 1'b1, 10'd1,  8'd1, 64'd1};
        vt[2]  = '{1'b0, 6'h00, 10'd0,  1'b1, 4, 1'b1, 10'd2,  8'd2, 64'd2};
        vt[3]  = '{1'b0, 6'h00, 10'd0,  1'b1, 3, 1'b1, 10'd3,  8'd3, 64'd3};
        vt[4]  = '{1'b0, 6'h00, 10'd0,  1'b1, 2, 1'b1, 10'd4,  8'd4, 64'd4};
        vt[5]  = '{1'b0, 6'h00, 10'd0,  1'b1, 1, 1'b1, 10'd5,  8'd5, 64'd5};
        vt[6]  = '{1'b0, 6'h00, 10'd0,  1'b1, 0, 1'b0, 10'd0,  8'd0, 64'd6};
        vt[7]  = '{1'b1, 6'h25, 10'd6,  1'b0, 3, 1'b1, 10'd6,  8'd0, 64'd6};
        vt[8]  = '{1'b0, 6'h00, 10'd0,  1'b0, 3, 1'b1, 10'd6,  8'd0, 64'd6};
        vt[9]  = '{1'b0, 6'h00, 10'd0,  1'b1, 2, 1'b1, 10'd7,  8'd2, 64'd7};
        vt[10] = '{1'b0, 6'h00, 10'd0,  1'b1, 1, 1'b1, 10'd8,  8'd5, 64'd8};
        vt[11] = '{1'b0, 6'h00, 10'd0,  1'b1, 0, 1'b0, 10'd0,  8'd0, 64'd9};
        vt[12] = '{1'b0, 6'h3F, 10'd40, 1'b1, 0, 1'b0, 10'd0,  8'd0, 64'd9};
        vt[13] = '{1'b1, 6'h03, 10'd9,  1'b1, 2, 1'b1, 10'd9,  8'd0, 64'd9};
        vt[14] = '{1'b1, 6'h01, 10'd11, 1'b1, 2, 1'b1, 10'd10, 8'd1, 64'd10};
        vt[15] = '{1'b0, 6'h00, 10'd0,  1'b1, 1, 1'b1, 10'd11, 8'd0, 64'd11};
        vt[16] = '{1'b0, 6'h00, 10'd0,  1'b1, 0, 1'b0, 10'd0,  8'd0, 64'd12};
        masks  = '{6'b000111, 6'b101010, 6'b111111, 6'b010000, 6'b110011, 6'b000001};

        rst           = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        step();
        step();
        chk("rst_occ", 64'(bus.occupancy), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_instr_cnt", bus.instr_cnt, 64'd0);
        chk("rst_err_ovf", 64'(bus.err_overflow), 64'd0);
        chk("rst_err_ord", 64'(bus.err_order), 64'd0);
        chk("rst_out_rec_nonzero", 64'(|bus.out_rec), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].en, vt[i].valid, vt[i].base, 8'd0);
            bus.out_ready = vt[i].rdy;
            step();
            chk($sformatf("v%0d_occ", i), 64'(bus.occupancy), 64'(vt[i].occ));
            chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vt[i].ovalid));
            chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
            chk($sformatf("v%0d_instr_cnt", i), bus.instr_cnt, vt[i].cnt);
            chk($sformatf("v%0d_err_ovf", i), 64'(bus.err_overflow), 64'd0);
            chk($sformatf("v%0d_err_ord", i), 64'(bus.err_order), 64'd0);
            if (vt[i].ovalid) begin
                h = bus.out_rec;
                chk($sformatf("v%0d_head_rob", i), 64'(h.robIdx), 64'(vt[i].rob));
                chk($sformatf("v%0d_head_lane", i), 64'(h.wdest), 64'(vt[i].wdest));
            end
        end

        // Overflow: fill with out_ready low until in_ready drops at occupancy 12.
        bus.out_ready = 1'b0;
        drive(1'b1, 6'h3F, 10'd12, 8'd0);
        step();
        chk("ovf_occ6", 64'(bus.occupancy), 64'd6);
        chk("ovf_ready6", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 6'h3F, 10'd18, 8'd0);
        step();
        chk("ovf_occ12", 64'(bus.occupancy), 64'd12);
        chk("ovf_ready12", 64'(bus.in_ready), 64'd0);
        chk("ovf_flag_clear", 64'(bus.err_overflow), 64'd0);
        drive(1'b1, 6'h3F, 10'd24, 8'd0);
        step();
        chk("ovf_occ_hold", 64'(bus.occupancy), 64'd12);
        chk("ovf_flag_set", 64'(bus.err_overflow), 64'd1);
        chk_head("ovf_head_stable", 10'd12);
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk_head($sformatf("ovf_drain%0d_rob", k), 10'(12 + k));
            step();
            chk($sformatf("ovf_drain%0d_occ", k), 64'(bus.occupancy), 64'(11 - k));
            chk($sformatf("ovf_drain%0d_ready", k), 64'(bus.in_ready),
                64'((DEPTH - (11 - k)) >= NL));
        end
        chk("ovf_instr_cnt", bus.instr_cnt, 64'd24);
        chk("ovf_err_ord", 64'(bus.err_order), 64'd0);
        chk("ovf_sticky", 64'(bus.err_overflow), 64'd1);

        // Wrap stream: 40 records, out_ready toggling, pointers wrap the buffer.
        m_occ = 0; sent = 0; drained = 0; mi = 0; nrob = 10'd24;
        for (int cyc = 0; cyc < 400 && !(sent >= 40 && m_occ == 0); cyc++) begin
            rdy = ((cyc % 2) == 1);
            if (m_occ > 0) begin
                chk($sformatf("wr%0d_out_valid", cyc), 64'(bus.out_valid), 64'd1);
                chk_head($sformatf("wr%0d_head_rob", cyc), q[0]);
            end else begin
                chk($sformatf("wr%0d_out_valid", cyc), 64'(bus.out_valid), 64'd0);
            end
            m = '0;
            n = 0;
            if (sent < 40 && m_occ <= DEPTH - NL) begin
                m  = masks[mi % 6];
                mi = mi + 1;
                n  = $countones(m);
                if (n > 40 - sent) begin
                    m = 6'b000001;
                    n = 1;
                end
                for (int k = 0; k < n; k++) q.push_back(nrob + 10'(k));
                drive(1'b1, m, nrob, 8'd0);
                nrob = nrob + 10'(n);
                sent = sent + n;
            end else begin
                drive(1'b0, '0, '0, '0);
            end
            bus.out_ready = rdy;
            deq = (m_occ > 0) && rdy;
            step();
            if (deq) begin
                void'(q.pop_front());
                drained++;
            end
            m_occ = m_occ + n - (deq ? 1 : 0);
            chk($sformatf("wr%0d_occ", cyc), 64'(bus.occupancy), 64'(m_occ));
            chk($sformatf("wr%0d_ready", cyc), 64'(bus.in_ready), 64'((DEPTH - m_occ) >= NL));
        end
        chk("wr_drained", 64'(drained), 64'd40);
        chk("wr_instr_cnt", bus.instr_cnt, 64'd64);
        chk("wr_err_ord", 64'(bus.err_order), 64'd0);

        // robIdx wrap 1023 -> 0 is legal; 3 -> 5 latches err_order; nFused=1 counts 2.
        rst = 1'b1;
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("ord_rst_cnt", bus.instr_cnt, 64'd0);
        chk("ord_rst_ovf", 64'(bus.err_overflow), 64'd0);
        bus.out_ready = 1'b1;
        drive(1'b1, 6'b011111, 10'd1023, 8'd0);
        step();
        chk("ord_occ_a", 64'(bus.occupancy), 64'd5);
        chk_head("ord_head_1023", 10'd1023);
        drive(1'b1, 6'b000001, 10'd5, 8'd0);
        step();
        chk("ord_occ_b", 64'(bus.occupancy), 64'd5);
        chk_head("ord_head_0", 10'd0);
        drive(1'b1, 6'b000001, 10'd6, 8'd1);
        step();
        chk_head("ord_head_1", 10'd1);
        chk("ord_wrap_no_err", 64'(bus.err_order), 64'd0);
        drive(1'b0, '0, '0, '0);
        step();
        step();
        step();
        chk_head("ord_head_5", 10'd5);
        chk("ord_cnt5", bus.instr_cnt, 64'd5);
        chk("ord_no_err_yet", 64'(bus.err_order), 64'd0);
        step();
        chk("ord_err_set", 64'(bus.err_order), 64'd1);
        chk("ord_cnt6", bus.instr_cnt, 64'd6);
        chk_head("ord_head_6", 10'd6);
        step();
        chk("ord_err_sticky", 64'(bus.err_order), 64'd1);
        chk("ord_cnt_fused", bus.instr_cnt, 64'd8);
        chk("ord_occ_empty", 64'(bus.occupancy), 64'd0);

        // Reset with five records held discards them without a drain.
        bus.out_ready = 1'b0;
        drive(1'b1, 6'b011111, 10'd100, 8'd0);
        step();
        chk("mr_occ5", 64'(bus.occupancy), 64'd5);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        step();
        rst = 1'b0;
        chk("mr_occ", 64'(bus.occupancy), 64'd0);
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_cnt", bus.instr_cnt, 64'd0);
        chk("mr_err_ord", 64'(bus.err_order), 64'd0);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mr_out_rec_nonzero", 64'(|bus.out_rec), 64'd0);
        step();
        chk("mr_post_occ", 64'(bus.occupancy), 64'd0);
        chk("mr_post_cnt", bus.instr_cnt, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
